// File: rtl/axil_mem_arbiter.sv
// Arbitrates an IMEM read port and a HOST read/write port onto one AXI-Lite
// memory master, one outstanding transaction at a time.
module axil_mem_arbiter #(
   parameter int unsigned AXI_AWIDTH = 32,
   parameter int unsigned AXI_DWIDTH = 32
) (
   input  logic                    AXI_ACLK,
   input  logic                    AXI_ARESETN,
   input  logic [AXI_AWIDTH-1:0]   IMEM_AXI_ARADDR,
   input  logic                    IMEM_AXI_ARVALID,
   output logic                    IMEM_AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0]   IMEM_AXI_RDATA,
   output logic [1:0]              IMEM_AXI_RRESP,
   output logic                    IMEM_AXI_RVALID,
   input  logic                    IMEM_AXI_RREADY,
   input  logic [AXI_AWIDTH-1:0]   HOST_AXI_AWADDR,
   input  logic                    HOST_AXI_AWVALID,
   output logic                    HOST_AXI_AWREADY,
   input  logic [AXI_DWIDTH-1:0]   HOST_AXI_WDATA,
   input  logic [AXI_DWIDTH/8-1:0] HOST_AXI_WSTRB,
   input  logic                    HOST_AXI_WVALID,
   output logic                    HOST_AXI_WREADY,
   output logic [1:0]              HOST_AXI_BRESP,
   output logic                    HOST_AXI_BVALID,
   input  logic                    HOST_AXI_BREADY,
   input  logic [AXI_AWIDTH-1:0]   HOST_AXI_ARADDR,
   input  logic                    HOST_AXI_ARVALID,
   output logic                    HOST_AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0]   HOST_AXI_RDATA,
   output logic [1:0]              HOST_AXI_RRESP,
   output logic                    HOST_AXI_RVALID,
   input  logic                    HOST_AXI_RREADY,
   output logic [AXI_AWIDTH-1:0]   MEM_AXI_AWADDR,
   output logic                    MEM_AXI_AWVALID,
   input  logic                    MEM_AXI_AWREADY,
   output logic [AXI_DWIDTH-1:0]   MEM_AXI_WDATA,
   output logic [AXI_DWIDTH/8-1:0] MEM_AXI_WSTRB,
   output logic                    MEM_AXI_WVALID,
   input  logic                    MEM_AXI_WREADY,
   input  logic [1:0]              MEM_AXI_BRESP,
   input  logic                    MEM_AXI_BVALID,
   output logic                    MEM_AXI_BREADY,
   output logic [AXI_AWIDTH-1:0]   MEM_AXI_ARADDR,
   output logic                    MEM_AXI_ARVALID,
   input  logic                    MEM_AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0]   MEM_AXI_RDATA,
   input  logic [1:0]              MEM_AXI_RRESP,
   input  logic                    MEM_AXI_RVALID,
   output logic                    MEM_AXI_RREADY,
   output logic                    ARB_BUSY,
   output logic [1:0]              ARB_GNT
);

   localparam int unsigned STRB_W = AXI_DWIDTH / 8;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_IMEM = 2'b01;
   localparam logic [1:0] GNT_HRD  = 2'b10;
   localparam logic [1:0] GNT_HWR  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B} state_e;

   state_e                state_q, state_d;
   logic [1:0]            gnt_q, gnt_d;
   logic                  rr_q, rr_d;
   logic                  last_wr_q, last_wr_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [AXI_AWIDTH-1:0] addr_q, addr_d;
   logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;

   logic       wreq, hrreq, irreq;
   logic [1:0] win;
   logic       aw_fin, w_fin, up_rready;

   assign IMEM_AXI_RDATA = MEM_AXI_RDATA;
   assign IMEM_AXI_RRESP = MEM_AXI_RRESP;
   assign HOST_AXI_RDATA = MEM_AXI_RDATA;
   assign HOST_AXI_RRESP = MEM_AXI_RRESP;
   assign HOST_AXI_BRESP = MEM_AXI_BRESP;

   assign MEM_AXI_AWADDR = addr_q;
   assign MEM_AXI_ARADDR = addr_q;
   assign MEM_AXI_WDATA  = wdata_q;
   assign MEM_AXI_WSTRB  = wstrb_q;

   assign ARB_BUSY = (state_q != S_IDLE);
   assign ARB_GNT  = gnt_q;

   // Winner selection: a write yields to any pending read right after a write.
   always_comb begin
      wreq  = HOST_AXI_AWVALID & HOST_AXI_WVALID;
      hrreq = HOST_AXI_ARVALID;
      irreq = IMEM_AXI_ARVALID;
      win   = GNT_NONE;
      if (wreq && !(last_wr_q && (hrreq || irreq))) begin
         win = GNT_HWR;
      end else if (hrreq && irreq) begin
         win = rr_q ? GNT_HRD : GNT_IMEM;
      end else if (hrreq) begin
         win = GNT_HRD;
      end else if (irreq) begin
         win = GNT_IMEM;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_d      = rr_q;
      last_wr_d = last_wr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;

      IMEM_AXI_ARREADY = 1'b0;
      IMEM_AXI_RVALID  = 1'b0;
      HOST_AXI_AWREADY = 1'b0;
      HOST_AXI_WREADY  = 1'b0;
      HOST_AXI_BVALID  = 1'b0;
      HOST_AXI_ARREADY = 1'b0;
      HOST_AXI_RVALID  = 1'b0;
      MEM_AXI_AWVALID  = 1'b0;
      MEM_AXI_WVALID   = 1'b0;
      MEM_AXI_BREADY   = 1'b0;
      MEM_AXI_ARVALID  = 1'b0;
      MEM_AXI_RREADY   = 1'b0;

      aw_fin    = aw_done_q | MEM_AXI_AWREADY;
      w_fin     = w_done_q | MEM_AXI_WREADY;
      up_rready = (gnt_q == GNT_IMEM) ? IMEM_AXI_RREADY : HOST_AXI_RREADY;

      unique case (state_q)
         S_IDLE: begin
            // Ready pulses are suppressed while reset is held.
            if (AXI_ARESETN) begin
               unique case (win)
                  GNT_HWR: begin
                     HOST_AXI_AWREADY = 1'b1;
                     HOST_AXI_WREADY  = 1'b1;
                     addr_d    = HOST_AXI_AWADDR;
                     wdata_d   = HOST_AXI_WDATA;
                     wstrb_d   = HOST_AXI_WSTRB;
                     last_wr_d = 1'b1;
                     gnt_d     = GNT_HWR;
                     state_d   = S_AW;
                  end
                  GNT_HRD: begin
                     HOST_AXI_ARREADY = 1'b1;
                     addr_d    = HOST_AXI_ARADDR;
                     last_wr_d = 1'b0;
                     gnt_d     = GNT_HRD;
                     state_d   = S_AR;
                  end
                  GNT_IMEM: begin
                     IMEM_AXI_ARREADY = 1'b1;
                     addr_d    = IMEM_AXI_ARADDR;
                     last_wr_d = 1'b0;
                     gnt_d     = GNT_IMEM;
                     state_d   = S_AR;
                  end
                  default: ;
               endcase
            end
         end
         S_AR: begin
            MEM_AXI_ARVALID = 1'b1;
            if (MEM_AXI_ARREADY) state_d = S_R;
         end
         S_R: begin
            IMEM_AXI_RVALID = (gnt_q == GNT_IMEM) & MEM_AXI_RVALID;
            HOST_AXI_RVALID = (gnt_q == GNT_HRD) & MEM_AXI_RVALID;
            MEM_AXI_RREADY  = up_rready;
            if (MEM_AXI_RVALID && up_rready) begin
               rr_d    = (gnt_q == GNT_IMEM);
               gnt_d   = GNT_NONE;
               state_d = S_IDLE;
            end
         end
         S_AW: begin
            MEM_AXI_AWVALID = ~aw_done_q;
            MEM_AXI_WVALID  = ~w_done_q;
            if (aw_fin && w_fin) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_B;
            end else begin
               aw_done_d = aw_fin;
               w_done_d  = w_fin;
            end
         end
         S_B: begin
            HOST_AXI_BVALID = MEM_AXI_BVALID;
            MEM_AXI_BREADY  = HOST_AXI_BREADY;
            if (MEM_AXI_BVALID && HOST_AXI_BREADY) begin
               gnt_d   = GNT_NONE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         state_q   <= S_IDLE;
         gnt_q     <= GNT_NONE;
         rr_q      <= 1'b0;
         last_wr_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_q      <= rr_d;
         last_wr_q <= last_wr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

endmodule

// File: doc/axil_mem_arbiter.md
AXIL_MEM_ARBITER -- requirements
Module: axil_mem_arbiter

Interface
REQ-001 Parameter AXI_AWIDTH, default 32, address width of all AR/AW channels.
REQ-002 Parameter AXI_DWIDTH, default 32, data width of all R/W channels; WSTRB width = AXI_DWIDTH/8.
REQ-003 AXI_ACLK  in  1  single clock; all logic rising-edge.
REQ-004 AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 IMEM AR channel:
- IMEM_AXI_ARADDR in AW
- IMEM_AXI_ARVALID in 1
- IMEM_AXI_ARREADY out 1
REQ-006 IMEM R channel:
- IMEM_AXI_RDATA out DW
- IMEM_AXI_RRESP out 2
- IMEM_AXI_RVALID out 1
- IMEM_AXI_RREADY in 1
REQ-007 HOST AW channel: HOST_AXI_AWADDR in AW; AWVALID in 1; AWREADY out 1.
REQ-008 HOST W channel: HOST_AXI_WDATA in DW; WSTRB in DW/8; WVALID in 1; WREADY out 1.
REQ-009 HOST B channel: HOST_AXI_BRESP out 2; BVALID out 1; BREADY in 1.
REQ-010 HOST AR channel: HOST_AXI_ARADDR in AW; ARVALID in 1; ARREADY out 1.
REQ-011 HOST R channel: HOST_AXI_RDATA out DW; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-012 MEM_AXI_* master port: AW, W, B, AR and R channels with the same signals and widths as the HOST port, directions mirrored (arbiter drives AW/W/AR valids, addresses, data, strobe, BREADY and RREADY).
REQ-013 ARB_BUSY  out  1  high in any state other than IDLE.
REQ-014 ARB_GNT  out  2  current owner: 00 none, 01 IMEM read, 10 HOST read, 11 HOST write.

Function
REQ-015 The FSM SHALL have states IDLE, AR, R, AW, B; exactly one transaction outstanding on MEM at any time.
REQ-016 Requests sampled in IDLE:
- WREQ = HOST AWVALID & WVALID
- HRREQ = HOST ARVALID
- IRREQ = IMEM ARVALID
REQ-017 Priority: WREQ wins unless the previous grant was a write and HRREQ|IRREQ is pending, in which case a read wins (no read starvation).
REQ-018 Between reads, round-robin bit rr selects: rr=0 prefers IMEM, rr=1 prefers HOST; rr toggles to the opposite requester after each completed read. A sole requester always wins.
REQ-019 Grant cycle (IDLE with a winner):
- Assert, for exactly one cycle, the winner's ARREADY, or HOST AWREADY and WREADY together.
- Latch address (and data/strobe for writes) into internal registers.
- Go to AR (read) or AW (write) on the next edge.
REQ-020 AR: MEM_AXI_ARVALID = 1 with the latched address, held stable until MEM_AXI_ARREADY; then go to R.
REQ-021 R:
- MEM_AXI_RDATA/RRESP routed to both upstream R ports combinationally.
- RVALID asserted only on the granted port; MEM_AXI_RREADY = granted RREADY.
- On handshake go to IDLE and update rr.
REQ-022 AW:
- MEM_AXI_AWVALID and MEM_AXI_WVALID asserted together; each deasserts independently after its own handshake (aw_done/w_done flags).
- When both are done go to B.
REQ-023 B:
- HOST BVALID = MEM_AXI_BVALID; BRESP passed through; MEM_AXI_BREADY = HOST BREADY.
- On handshake go to IDLE.
REQ-024 Non-granted upstream READY/VALID outputs SHALL be 0 at all times; RRESP/BRESP error codes SHALL pass through unmodified.
REQ-025 Minimum read latency with a zero-wait MEM: ARREADY pulse at cycle 0, MEM ARVALID at cycle 1, upstream RVALID at cycle 2 or later; next grant no earlier than the cycle after R completes.
REQ-026 Requests arriving outside IDLE SHALL be held off (READY low) and are not lost; their VALID stays asserted per AXI rules.

Reset
REQ-027 While AXI_ARESETN = 0:
- state IDLE; rr = 0; aw_done = w_done = 0; last grant = read.
- All VALID/READY outputs, ARB_BUSY and ARB_GNT are 0; latched address/data registers are 0.
REQ-028 Reset asserted mid-transaction SHALL abort immediately (asynchronously) to IDLE; the aborted transaction is not replayed.

Verification
REQ-029 IMEM read 0x100 alone, MEM ready with 0 wait -> IMEM_AXI_ARREADY pulses 1 cycle; MEM ARADDR=0x100; RDATA returned; ARB_GNT=01; rr=1 after completion.
REQ-030 IMEM and HOST reads both pending continuously -> grants alternate IMEM, HOST, IMEM, HOST; no port is granted twice in a row.
REQ-031 HOST write 0xF0000004 data 0xDEADBEEF strb 0xF, with MEM AWREADY 2 cycles before WREADY -> AWVALID drops first, WVALID holds, B forwarded; BRESP=00.
REQ-032 Continuous HOST write plus pending IMEM read -> order W, R, W, R.
REQ-033 MEM returns RRESP=10 on a HOST read -> HOST_AXI_RRESP=10; IMEM_AXI_RVALID stays 0.
REQ-034 Reset pulsed while in R with MEM RVALID low -> all outputs 0 at once; after release a new IMEM request is granted normally.
